// File: rtl/delayed_data_mem.sv
// Data memory with a fixed, parameterised access latency for a 5-stage pipeline.
// Raises mem_busy to stall the pipeline and pulses mem_done when an access completes.
module delayed_data_mem #(
   parameter int MEM_DELAY = 3,
   parameter int ADDR_W    = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreadm,
   input  logic        memwritem,
   input  logic [31:0] aluoutm,
   input  logic [31:0] writedatam,
   output logic [31:0] readdatam,
   output logic        mem_busy,
   output logic        mem_done
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] index;
   logic              unused_addr_bits;

   // Byte offset and upper bits are dropped, so addresses wrap around the array.
   assign index            = aluoutm[ADDR_W+1:2];
   assign unused_addr_bits = ^{aluoutm[31:ADDR_W+2], aluoutm[1:0]};

   if (MEM_DELAY == 0) begin : g_direct

      logic unused_ctrl;
      assign unused_ctrl = ^{reset, memreadm};

      // NOTE: the memory array has no reset; only control state is reset, contents survive.
      always_ff @(posedge clk) begin
         if (memwritem) mem[index] <= writedatam;
      end

      assign readdatam = mem[index];
      assign mem_busy  = 1'b0;
      assign mem_done  = 1'b0;

   end else begin : g_stalled

      typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

      localparam logic [3:0] CNT_LOAD = (MEM_DELAY >= 2) ? 4'(MEM_DELAY - 2) : 4'd0;

      state_t            state, state_nxt;
      logic [3:0]        cnt;
      logic [ADDR_W-1:0] idx_q;
      logic [31:0]       data_q;
      logic              we_q;
      logic              req, start, enter_done;
      logic [ADDR_W-1:0] acc_idx;
      logic [31:0]       acc_data;
      logic              acc_we;

      assign req        = memreadm | memwritem;
      assign start      = (state == IDLE) && req;
      assign enter_done = (state_nxt == DONE);

      // With a one-cycle delay DONE is entered on the latching edge itself,
      // so the values being latched are used directly.
      assign acc_idx  = start ? index      : idx_q;
      assign acc_data = start ? writedatam : data_q;
      assign acc_we   = start ? memwritem  : we_q;

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) state <= IDLE;
         else       state <= state_nxt;
      end

      // NOTE: defaults first so no path through the block leaves a signal unassigned (no latch).
      always_comb begin
         state_nxt = state;
         unique case (state)
            IDLE:    if (req) state_nxt = (MEM_DELAY == 1) ? DONE : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end

      always_comb begin
         mem_busy = 1'b0;
         mem_done = 1'b0;
         unique case (state)
            IDLE:    mem_busy = req & ~reset;
            WAIT:    mem_busy = 1'b1;
            DONE:    mem_done = 1'b1;
            default: mem_busy = 1'b0;
         endcase
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt       <= 4'd0;
            idx_q     <= '0;
            data_q    <= 32'd0;
            we_q      <= 1'b0;
            readdatam <= 32'd0;
         end else begin
            if (start) begin
               idx_q  <= index;
               data_q <= writedatam;
               we_q   <= memwritem;
               cnt    <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end
            if (enter_done && !acc_we) readdatam <= mem[acc_idx];
         end
      end

      always_ff @(posedge clk) begin
         if (enter_done && acc_we) mem[acc_idx] <= acc_data;
      end

   end

endmodule

// File: tb/tb_delayed_data_mem.sv
// Self-checking bench for delayed_data_mem at MEM_DELAY = 0, 1 and 3.
// Load results are scoreboarded against a reference memory per instance.
module tb_delayed_data_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        memreadm, memwritem;
   logic [31:0] aluoutm, writedatam;
   logic [31:0] rd0, rd1, rd3;
   logic        busy0, busy1, busy3;
   logic        done0, done1, done3;

   int checks = 0;
   int errors = 0;

   // Slot 0 -> MEM_DELAY 0, slot 1 -> MEM_DELAY 1, slot 2 -> MEM_DELAY 3
   logic [31:0] ref_mem [3][64];
   logic [31:0] last_rd [3];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   delayed_data_mem #(.MEM_DELAY(0), .ADDR_W(6)) u_d0 (
      .clk(clk), .reset(reset), .memreadm(memreadm), .memwritem(memwritem),
      .aluoutm(aluoutm), .writedatam(writedatam),
      .readdatam(rd0), .mem_busy(busy0), .mem_done(done0));

   delayed_data_mem #(.MEM_DELAY(1), .ADDR_W(6)) u_d1 (
      .clk(clk), .reset(reset), .memreadm(memreadm), .memwritem(memwritem),
      .aluoutm(aluoutm), .writedatam(writedatam),
      .readdatam(rd1), .mem_busy(busy1), .mem_done(done1));

   delayed_data_mem #(.MEM_DELAY(3), .ADDR_W(6)) u_d3 (
      .clk(clk), .reset(reset), .memreadm(memreadm), .memwritem(memwritem),
      .aluoutm(aluoutm), .writedatam(writedatam),
      .readdatam(rd3), .mem_busy(busy3), .mem_done(done3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd_of(input int slot);
      case (slot)
         0:       return rd0;
         1:       return rd1;
         default: return rd3;
      endcase
   endfunction

   function automatic logic busy_of(input int slot);
      case (slot)
         0:       return busy0;
         1:       return busy1;
         default: return busy3;
      endcase
   endfunction

   function automatic logic done_of(input int slot);
      case (slot)
         0:       return done0;
         1:       return done1;
         default: return done3;
      endcase
   endfunction

   function automatic int word_of(input logic [31:0] addr);
      return int'((addr >> 2) % 64);
   endfunction

   task automatic apply_reset(input int slot);
      memreadm   = 1'b0;
      memwritem  = 1'b0;
      aluoutm    = 32'd0;
      writedatam = 32'd0;
      reset      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy_of(slot)), 32'd0);
      check("reset_done", 32'(done_of(slot)), 32'd0);
      if (slot != 0) check("reset_rd", rd_of(slot), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
   endtask

   // Called just after a rising edge with the DUT idle; returns just after the
   // edge that leaves DONE.
   task automatic do_access(input int slot, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input bit scramble, input bit both);
      int          d;
      int          busy_n;
      bit          done_seen;
      logic [31:0] e;
      d         = (slot == 2) ? 3 : slot;
      busy_n    = 0;
      done_seen = 1'b0;
      memreadm   = !wr || both;
      memwritem  = wr;
      aluoutm    = addr;
      writedatam = data;
      if (wr) ref_mem[slot][word_of(addr)] = data;
      else    exp_q.push_back(ref_mem[slot][word_of(addr)]);
      for (int c = 0; c < 20 && !done_seen; c++) begin
         @(negedge clk);
         if (busy_of(slot)) busy_n++;
         if (d == 0) check("d0_done_low", 32'(done_of(slot)), 32'd0);
         if (done_of(slot) || d == 0) begin
            done_seen = 1'b1;
            if (!wr) begin
               e = exp_q.pop_front();
               check("load_data", rd_of(slot), e);
               last_rd[slot] = e;
            end else if (d != 0) begin
               check("store_keeps_rd", rd_of(slot), last_rd[slot]);
            end
         end
         @(posedge clk);
         #1;
         memreadm  = 1'b0;
         memwritem = 1'b0;
         if (scramble) begin
            aluoutm    = addr + 32'h4;
            writedatam = ~data;
         end
      end
      check("busy_cycles", busy_n, d);
      check("access_done", 32'(done_seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // ---------------- MEM_DELAY = 3 ----------------
      apply_reset(2);
      do_access(2, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
      do_access(2, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0);

      // Back-to-back loads with memreadm held high
      do_access(2, 1'b1, 32'h0, 32'h1111_0000, 1'b0, 1'b0);
      do_access(2, 1'b1, 32'h4, 32'h2222_0004, 1'b0, 1'b0);
      exp_q.push_back(ref_mem[2][0]);
      exp_q.push_back(ref_mem[2][1]);
      memreadm = 1'b1;
      aluoutm  = 32'h0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("b2b_busy", 32'(busy3), 32'((i % 4) != 3));
         check("b2b_done", 32'(done3), 32'((i % 4) == 3));
         if (done3 && exp_q.size() > 0) begin
            check("b2b_load", rd3, exp_q.pop_front());
            aluoutm = 32'h4;
         end
      end
      @(posedge clk);
      #1;
      memreadm      = 1'b0;
      last_rd[2]    = ref_mem[2][1];

      // Inputs changed during WAIT must not disturb the latched store
      do_access(2, 1'b1, 32'h24, 32'h2424_2424, 1'b0, 1'b0);
      do_access(2, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b1, 1'b0);
      do_access(2, 1'b0, 32'h20, 32'h0,         1'b0, 1'b0);
      do_access(2, 1'b0, 32'h24, 32'h0,         1'b0, 1'b0);

      // Address wrap: 0x104 aliases word 1
      do_access(2, 1'b1, 32'h104, 32'h0BAD_F00D, 1'b0, 1'b0);
      do_access(2, 1'b0, 32'h4,   32'h0,         1'b0, 1'b0);

      // Read and write together is a store only
      do_access(2, 1'b1, 32'h30, 32'h5A5A_0030, 1'b0, 1'b1);
      do_access(2, 1'b0, 32'h30, 32'h0,         1'b0, 1'b0);

      // Reset in the second busy cycle of a store discards it
      do_access(2, 1'b1, 32'h8, 32'hA5A5_A5A5, 1'b0, 1'b0);
      do_access(2, 1'b0, 32'h8, 32'h0,         1'b0, 1'b0);
      memwritem  = 1'b1;
      aluoutm    = 32'h8;
      writedatam = 32'h1234_5678;
      @(posedge clk);
      #1;
      memwritem = 1'b0;
      check("busy_before_reset", 32'(busy3), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("rst_busy", 32'(busy3), 32'd0);
      check("rst_done", 32'(done3), 32'd0);
      check("rst_rd",   rd3,        32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      last_rd[2] = 32'd0;
      do_access(2, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);

      // ---------------- MEM_DELAY = 1 ----------------
      apply_reset(1);
      do_access(1, 1'b1, 32'h4,  32'h0101_0004, 1'b0, 1'b0);
      do_access(1, 1'b1, 32'h8,  32'h0101_0008, 1'b0, 1'b0);
      do_access(1, 1'b0, 32'h4,  32'h0,         1'b0, 1'b0);
      do_access(1, 1'b0, 32'h8,  32'h0,         1'b0, 1'b0);
      do_access(1, 1'b1, 32'h4,  32'h7777_7777, 1'b0, 1'b1);
      do_access(1, 1'b0, 32'h4,  32'h0,         1'b0, 1'b0);

      // ---------------- MEM_DELAY = 0 ----------------
      apply_reset(0);
      do_access(0, 1'b1, 32'h40,  32'h0000_0040, 1'b0, 1'b0);
      do_access(0, 1'b0, 32'h40,  32'h0,         1'b0, 1'b0);
      do_access(0, 1'b1, 32'h104, 32'hF00D_0104, 1'b0, 1'b0);
      do_access(0, 1'b0, 32'h4,   32'h0,         1'b0, 1'b0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
